// File: rtl/sram2axi_bridge.sv
// sram2axi_bridge: converts the core's SRAM-like instruction and data ports
// into single-beat AXI3 transactions, one transaction in flight at a time.
// Data requests take priority over instruction fetches when both arrive together.
module sram2axi_bridge (
    input  logic        clk,
    input  logic        resetn,

    // instruction fetch port
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    // data load/store port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    // AXI write address channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    // AXI write data channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    // AXI write response channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_e;

    state_e      state_q;
    logic        srcIsData_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        awvalid_q;
    logic        wvalid_q;

    logic        isIdle;
    logic        acceptData;
    logic        acceptInst;
    logic        awDone;
    logic        wDone;
    logic [1:0]  effSize;
    logic [3:0]  strbMask;
    logic        unusedAxiFields;

    // Single-beat bursts only, and responses are trusted; these fields carry nothing we use.
    assign unusedAxiFields = ^{rid, rresp, rlast, bid, bresp, wr_q};

    assign isIdle     = (state_q == IDLE);
    assign acceptData = isIdle && data_req;
    assign acceptInst = isIdle && inst_req && !data_req;

    // The address handshakes must fall silent while reset is held, even though
    // the state register already reads IDLE.
    assign data_addr_ok = resetn && acceptData;
    assign inst_addr_ok = resetn && acceptInst;

    // Each write channel is finished once its valid has been accepted, now or earlier.
    assign awDone = !awvalid_q || awready;
    assign wDone  = !wvalid_q  || wready;

    // Size code 3 has no wider meaning on a 32-bit bus, so it behaves as a word.
    assign effSize = (size_q == 2'd3) ? 2'd2 : size_q;

    // Byte lanes touched by the latched store, aligned within the word.
    always_comb begin
        strbMask = 4'b0000;
        case (effSize)
            2'd0:    strbMask = 4'b0001 << addr_q[1:0];
            2'd1:    strbMask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: strbMask = 4'b1111;
        endcase
    end

    // Transaction sequencer: latches the accepted request and walks the AXI handshakes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            srcIsData_q <= 1'b0;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acceptData) begin
                        srcIsData_q <= 1'b1;
                        wr_q        <= data_wr;
                        size_q      <= data_size;
                        addr_q      <= data_addr;
                        wdata_q     <= data_wdata;
                        if (data_wr) begin
                            state_q   <= WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q <= RD_ADDR;
                        end
                    end else if (acceptInst) begin
                        srcIsData_q <= 1'b0;
                        wr_q        <= 1'b0;
                        size_q      <= inst_size;
                        addr_q      <= inst_addr;
                        wdata_q     <= 32'd0;
                        state_q     <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        state_q <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (awDone && wDone) begin
                        state_q   <= WR_RESP;
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                    end else begin
                        awvalid_q <= awvalid_q && !awready;
                        wvalid_q  <= wvalid_q && !wready;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read address channel
    assign arid    = srcIsData_q ? 4'd1 : 4'd0;
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, effSize};
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state_q == RD_ADDR);

    // Read data channel: data is forwarded untouched, data_ok qualifies it.
    assign rready       = (state_q == RD_DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign inst_data_ok = rready && rvalid && !srcIsData_q;

    // Write address and data channels
    assign awid    = 4'd1;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, effSize};
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;

    assign wid    = 4'd1;
    assign wdata  = wdata_q;
    assign wstrb  = strbMask;
    assign wlast  = 1'b1;
    assign wvalid = wvalid_q;

    // Write response channel; data_data_ok covers both load data and store completion.
    assign bready       = (state_q == WR_RESP);
    assign data_data_ok = (rready && rvalid && srcIsData_q) || (bready && bvalid);

endmodule

// File: tb/tb_sram2axi_bridge.sv
// Self-checking bench for sram2axi_bridge: table vectors, hand sequences for
// arbitration/reset corners, and randomized transactions against a reference model.
module tb_sram2axi_bridge;

    localparam int BOUND = 40;

    typedef struct {
        bit          isData;
        bit          wr;
        bit          bothReq;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          arDly;
        int          rDly;
        int          awDly;
        int          wDly;
        int          bDly;
        logic [3:0]  expStrb;
        logic [2:0]  expSize;
        logic [3:0]  expId;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int    checks = 0;
    int    errors = 0;
    string curTag = "";

    sram2axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", curTag, name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s %s: timed out after %0d cycles", curTag, name, BOUND);
    endtask

    // Reference model: lanes and size from the byte count of the access.
    function automatic vec_t modelExpect(input vec_t v);
        vec_t r;
        int   eff, bytes, off;
        r     = v;
        eff   = (v.size == 2'd3) ? 2 : int'(v.size);
        bytes = 1 << eff;
        off   = int'(v.addr % 4) & ~(bytes - 1);
        r.expStrb = 4'(((1 << bytes) - 1) << off);
        r.expSize = 3'(eff);
        r.expId   = v.isData ? 4'd1 : 4'd0;
        return r;
    endfunction

    function automatic vec_t mkVec(input bit isData, input bit wr, input bit bothReq,
                                   input logic [1:0] size, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rd,
                                   input int arD, input int rD, input int awD, input int wD,
                                   input int bD, input logic [3:0] strb, input logic [2:0] sz,
                                   input logic [3:0] id);
        vec_t v;
        v.isData = isData; v.wr = wr; v.bothReq = bothReq; v.size = size; v.addr = addr;
        v.wdata = wd; v.rdata = rd; v.arDly = arD; v.rDly = rD; v.awDly = awD; v.wDly = wD;
        v.bDly = bD; v.expStrb = strb; v.expSize = sz; v.expId = id;
        return v;
    endfunction

    // Runs one full transaction; called at posedge+1 and returns at posedge+1 or later.
    task automatic applyStimulus(input vec_t v);
        int cyc;
        bit done, awSeen, wSeen;
        rid = 4'($urandom); rresp = 2'($urandom); rlast = 1'($urandom);
        bid = 4'($urandom); bresp = 2'($urandom);
        if (v.isData) begin
            data_req = 1'b1; data_wr = v.wr; data_size = v.size;
            data_addr = v.addr; data_wdata = v.wdata;
            inst_req = v.bothReq; inst_addr = $urandom; inst_size = 2'($urandom);
        end else begin
            inst_req = 1'b1; inst_size = v.size; inst_addr = v.addr;
            data_req = 1'b0;
        end
        #1;
        checkOutput("dataAddrOk", data_addr_ok, v.isData);
        checkOutput("instAddrOk", inst_addr_ok, !v.isData);
        @(posedge clk); #1;
        inst_req = 1'b0; data_req = 1'b0;
        data_addr = $urandom; data_wdata = $urandom; inst_addr = $urandom;
        if (!v.wr) begin
            cyc = 0; done = 0;
            while (!done && cyc < BOUND) begin
                arready = (cyc >= v.arDly);
                #1;
                checkOutput("arvalid", arvalid, 1);
                checkOutput("araddr", araddr, v.addr);
                checkOutput("arsize", arsize, v.expSize);
                checkOutput("arid", arid, v.expId);
                if (arready) done = 1;
                else begin @(posedge clk); #1; cyc++; end
            end
            if (!done) timeoutFail("arHandshake");
            @(posedge clk); #1;
            arready = 1'b0;
            cyc = 0; done = 0;
            while (!done && cyc < BOUND) begin
                rvalid = (cyc >= v.rDly);
                rdata  = v.rdata;
                #1;
                checkOutput("rready", rready, 1);
                checkOutput("arvalidAfterAr", arvalid, 0);
                checkOutput("instDataOk", inst_data_ok, rvalid && !v.isData);
                checkOutput("dataDataOk", data_data_ok, rvalid && v.isData);
                checkOutput("rdataPass", v.isData ? data_rdata : inst_rdata, v.rdata);
                if (rvalid) done = 1;
                else begin @(posedge clk); #1; cyc++; end
            end
            if (!done) timeoutFail("rHandshake");
            @(posedge clk); #1;
            rvalid = 1'b0;
            #1;
            checkOutput("rreadyIdle", rready, 0);
            checkOutput("dataOkIdle", {inst_data_ok, data_data_ok}, 0);
        end else begin
            cyc = 0; done = 0; awSeen = 0; wSeen = 0;
            while (!done && cyc < BOUND) begin
                awready = (cyc >= v.awDly);
                wready  = (cyc >= v.wDly);
                #1;
                checkOutput("awvalid", awvalid, !awSeen);
                checkOutput("wvalid", wvalid, !wSeen);
                checkOutput("awaddr", awaddr, v.addr);
                checkOutput("awsize", awsize, v.expSize);
                checkOutput("wstrb", wstrb, v.expStrb);
                checkOutput("wdata", wdata, v.wdata);
                checkOutput("wIdsLast", {awid, wid, wlast}, {4'd1, 4'd1, 1'b1});
                checkOutput("dataOkEarly", data_data_ok, 0);
                if (awready) awSeen = 1;
                if (wready) wSeen = 1;
                if (awSeen && wSeen) done = 1;
                else begin @(posedge clk); #1; cyc++; end
            end
            if (!done) timeoutFail("awwHandshake");
            @(posedge clk); #1;
            awready = 1'b0; wready = 1'b0;
            cyc = 0; done = 0;
            while (!done && cyc < BOUND) begin
                bvalid = (cyc >= v.bDly);
                #1;
                checkOutput("bready", bready, 1);
                checkOutput("awwDropped", {awvalid, wvalid}, 0);
                checkOutput("dataDataOkB", data_data_ok, bvalid);
                checkOutput("instDataOkB", inst_data_ok, 0);
                if (bvalid) done = 1;
                else begin @(posedge clk); #1; cyc++; end
            end
            if (!done) timeoutFail("bHandshake");
            @(posedge clk); #1;
            bvalid = 1'b0;
            #1;
            checkOutput("dataOkOnePulse", data_data_ok, 0);
            checkOutput("breadyIdle", bready, 0);
        end
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rvalid = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;

        vecs[0] = mkVec(1, 0, 1, 2'd2, 32'h1FC0_0010, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 4'hF, 3'd2, 4'd1);
        vecs[1] = mkVec(1, 1, 0, 2'd0, 32'h8000_0003, 32'hAABB_CCDD, 0, 0, 0, 0, 0, 0, 4'b1000, 3'd0, 4'd1);
        vecs[2] = mkVec(1, 1, 0, 2'd2, 32'h8000_1000, 32'h0BAD_F00D, 0, 0, 0, 3, 0, 1, 4'b1111, 3'd2, 4'd1);
        vecs[3] = mkVec(0, 0, 0, 2'd2, 32'hBFC0_0000, 0, 32'h2402_0001, 5, 0, 0, 0, 0, 4'hF, 3'd2, 4'd0);
        vecs[4] = mkVec(1, 1, 0, 2'd1, 32'h0000_0102, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 4'b1100, 3'd1, 4'd1);
        vecs[5] = mkVec(1, 1, 0, 2'd1, 32'h0000_0101, 32'h3333_4444, 0, 0, 0, 1, 1, 2, 4'b0011, 3'd1, 4'd1);
        vecs[6] = mkVec(1, 1, 0, 2'd3, 32'h0000_0205, 32'h5555_6666, 0, 0, 0, 0, 2, 0, 4'b1111, 3'd2, 4'd1);
        vecs[7] = mkVec(1, 0, 0, 2'd0, 32'h0000_0301, 0, 32'hCAFE_0001, 2, 3, 0, 0, 0, 4'hF, 3'd0, 4'd1);
        vecs[8] = mkVec(0, 0, 0, 2'd3, 32'h0000_0400, 0, 32'h8765_4321, 0, 2, 0, 0, 0, 4'hF, 3'd2, 4'd0);

        // Reset state: requests are ignored and all handshakes are low.
        curTag = "reset";
        repeat (2) @(posedge clk);
        #1;
        data_req = 1'b1; inst_req = 1'b1;
        #1;
        checkOutput("addrOk", {inst_addr_ok, data_addr_ok}, 0);
        checkOutput("valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        checkOutput("dataOk", {inst_data_ok, data_data_ok}, 0);
        checkOutput("araddr", araddr, 0);
        data_req = 1'b0; inst_req = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            curTag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
        end

        // A request present while data_ok pulses is only accepted the next cycle.
        curTag = "noAcceptOnDataOk";
        inst_req = 1'b1; inst_addr = 32'h0000_0040; inst_size = 2'd2;
        #1;
        checkOutput("instAddrOk", inst_addr_ok, 1);
        @(posedge clk); #1;
        inst_req = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0101_0202;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0080; data_size = 2'd2;
        #1;
        checkOutput("instDataOk", inst_data_ok, 1);
        checkOutput("dataAddrOkBlocked", data_addr_ok, 0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        #1;
        checkOutput("dataAddrOkNext", data_addr_ok, 1);
        @(posedge clk); #1;
        data_req = 1'b0; arready = 1'b1;
        #1;
        checkOutput("arid", arid, 1);
        checkOutput("araddr", araddr, 32'h0000_0080);
        @(posedge clk); #1;
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0303_0404;
        #1;
        checkOutput("dataDataOk", data_data_ok, 1);
        @(posedge clk); #1;
        rvalid = 1'b0;

        // Reset while waiting on read data abandons the fetch.
        curTag = "midReset";
        inst_req = 1'b1; inst_addr = 32'h1FC0_0100; inst_size = 2'd2;
        @(posedge clk); #1;
        inst_req = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        #1;
        checkOutput("rreadyBefore", rready, 1);
        resetn = 1'b0;
        #1;
        checkOutput("rreadyInReset", rready, 0);
        checkOutput("arvalidInReset", arvalid, 0);
        checkOutput("araddrCleared", araddr, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("lateRvalidNoOk", {inst_data_ok, data_data_ok}, 0);
        checkOutput("rreadyAfter", rready, 0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        applyStimulus(mkVec(0, 0, 0, 2'd2, 32'h1FC0_0104, 0, 32'h0000_0ABC, 1, 1, 0, 0, 0, 4'hF, 3'd2, 4'd0));

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            curTag = $sformatf("rand%0d", n);
            rv.isData  = 1'($urandom);
            rv.wr      = rv.isData ? 1'($urandom) : 1'b0;
            rv.bothReq = rv.isData ? 1'($urandom) : 1'b0;
            rv.size    = 2'($urandom);
            rv.addr    = $urandom;
            rv.wdata   = $urandom;
            rv.rdata   = $urandom;
            rv.arDly   = $urandom_range(0, 3);
            rv.rDly    = $urandom_range(0, 3);
            rv.awDly   = $urandom_range(0, 3);
            rv.wDly    = $urandom_range(0, 3);
            rv.bDly    = $urandom_range(0, 3);
            rv = modelExpect(rv);
            applyStimulus(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
